// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between core (port 0) and secondary master (port 1) with bounded locked bursts.
// Optional contention counters enabled with `define ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [15:0]   deny_cnt0,
  output logic [15:0]   deny_cnt1
);
  typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_e;
  localparam logic [8:0] MB = 9'(MAX_BURST);
  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] beat_q, beat_d;
  logic       hold, hn, beat_ok;
  assign hold    = state_q != ARB;
  assign hn      = state_q == HOLD1;
  assign beat_ok = ({1'b0, beat_q} + 9'd1) < MB;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      rr_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end
  // A release always hands preference to the other port, so a waiting master wins next.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    if (!hold) begin
      if (gnt0 || gnt1) begin
        rr_d = !gnt1;
        if ((gnt1 ? lock1 : lock0) && MAX_BURST > 1) begin
          state_d = gnt1 ? HOLD1 : HOLD0;
          beat_d  = 8'd1;
        end
      end
    end else if ((hn ? gnt1 && lock1 : gnt0 && lock0) && beat_ok) begin
      beat_d = beat_q + 8'd1;
    end else begin
      state_d = ARB;
      beat_d  = '0;
      rr_d    = !hn;
    end
  end
  always_comb begin
    gnt0   = !reset && req0 && (hold ? !hn : (!req1 || !rr_q));
    gnt1   = !reset && req1 && (hold ? hn : (!req0 || rr_q));
    mem_a  = gnt0 ? adr0 : gnt1 ? adr1 : '0;
    mem_wd = gnt0 ? wd0 : gnt1 ? wd1 : '0;
    mem_we = (gnt0 && we0) || (gnt1 && we1);
    rd0    = gnt0 ? mem_rd : '0;
    rd1    = gnt1 ? mem_rd : '0;
  end
`ifdef ARB_STATS_EN
  logic [15:0] deny0_q, deny1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      deny0_q <= '0;
      deny1_q <= '0;
    end else begin
      if (req0 && !gnt0 && deny0_q != 16'hFFFF) deny0_q <= deny0_q + 16'd1;
      if (req1 && !gnt1 && deny1_q != 16'hFFFF) deny1_q <= deny1_q + 16'd1;
    end
  end
  assign deny_cnt0 = deny0_q;
  assign deny_cnt1 = deny1_q;
`else
  assign deny_cnt0 = '0;
  assign deny_cnt1 = '0;
`endif
endmodule
